ysyx_isu: RTL and testbench

- In-order issue stage directly downstream of the decoded micro-op queue.
- Takes the queue head and checks a per-register busy scoreboard for RAW and WAW hazards.
- Issues hazard-free ops into a single registered output slot toward the execute/dispatch stage.
- Clears scoreboard bits on writeback; a flush discards the slot and the whole scoreboard.

---
 rtl/ysyx_isu.sv | 153 +++++++++++++++
 tb/tb_ysyx_isu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_isu.sv
// ysyx_isu: in-order issue stage with a per-register busy scoreboard and one
// registered issue slot. Same-cycle writebacks unblock waiting ops combinationally.
module ysyx_isu #(
  parameter int REG_NUM   = 16,
  parameter int REG_LEN   = 4,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_uop,
  input  logic [REG_LEN-1:0]   in_rd,
  input  logic                 in_rd_en,
  input  logic [REG_LEN-1:0]   in_rs1,
  input  logic                 in_rs1_en,
  input  logic [REG_LEN-1:0]   in_rs2,
  input  logic                 in_rs2_en,
  input  logic                 wb_valid,
  input  logic [REG_LEN-1:0]   wb_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_uop,
  output logic [REG_LEN-1:0]   out_rd,
  output logic                 out_rd_en,
  output logic [REG_NUM-1:0]   busy,
  output logic [31:0]          stall_cnt
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e            state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [PAYLOAD_W-1:0]   uop_q, uop_d;
  logic [REG_LEN-1:0]     rd_q, rd_d;
  logic                   rd_en_q, rd_en_d;
  logic [REG_NUM-1:0]     busy_q, busy_d;
  logic [31:0]            stall_q, stall_d;

  logic [REG_NUM-1:0]     wb_mask;
  logic [REG_NUM-1:0]     set_mask;
  logic [REG_NUM-1:0]     eff_busy;
  logic                   hazard;
  logic                   slot_free;
  logic                   accept;
  logic                   stall_cycle;

  // An operand only blocks when it is enabled, is not x0 and is still in flight.
  function automatic logic operand_blocked(input logic               en,
                                           input logic [REG_LEN-1:0] idx,
                                           input logic [REG_NUM-1:0] eff);
    return en && (idx != '0) && eff[idx];
  endfunction

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wb_mask = '0;
    if (wb_valid && (wb_rd != '0)) begin
      wb_mask[wb_rd] = 1'b1;
    end
  end

  assign eff_busy  = busy_q & ~wb_mask;
  assign hazard    = operand_blocked(in_rs1_en, in_rs1, eff_busy)
                   | operand_blocked(in_rs2_en, in_rs2, eff_busy)
                   | operand_blocked(in_rd_en,  in_rd,  eff_busy);
  assign out_valid = (state_q == SLOT_FULL);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    set_mask = '0;
    if (accept && in_rd_en && (in_rd != '0)) begin
      set_mask[in_rd] = 1'b1;
    end
  end

  // Hazard stalls are counted only when the slot itself could take the op.
  assign stall_cycle = in_valid && hazard && slot_free && !flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    uop_d   = uop_q;
    rd_d    = rd_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    stall_d = stall_q;

    if (flush) begin
      state_d = SLOT_EMPTY;
      busy_d  = '0;
    end else begin
      // Set is applied after clear so a fresh producer wins on the same index.
      busy_d = (busy_q & ~wb_mask) | set_mask;
      if (accept) begin
        state_d = SLOT_FULL;
        pc_d    = in_pc;
        uop_d   = in_uop;
        rd_d    = in_rd;
        rd_en_d = in_rd_en;
      end else if (out_ready) begin
        state_d = SLOT_EMPTY;
      end
    end

    if (stall_cycle && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end

    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering between blocks is moot.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the payload registers are reset as well because the outputs are
      // promised to read zero after reset; a pure datapath would skip this.
      state_q <= SLOT_EMPTY;
      pc_q    <= '0;
      uop_q   <= '0;
      rd_q    <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      uop_q   <= uop_d;
      rd_q    <= rd_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_uop   = uop_q;
  assign out_rd    = rd_q;
  assign out_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ysyx_isu.sv
// tb_ysyx_isu: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a behavioural scoreboard model.
module tb_ysyx_isu;
  localparam int REG_NUM   = 16;
  localparam int REG_LEN   = 4;
  localparam int PAYLOAD_W = 128;

  logic                 clock = 1'b0;
  logic                 reset, flush;
  logic                 in_valid, in_ready;
  logic [31:0]          in_pc;
  logic [PAYLOAD_W-1:0] in_uop;
  logic [REG_LEN-1:0]   in_rd, in_rs1, in_rs2, wb_rd;
  logic                 in_rd_en, in_rs1_en, in_rs2_en, wb_valid;
  logic                 out_valid, out_ready, out_rd_en;
  logic [31:0]          out_pc, stall_cnt;
  logic [PAYLOAD_W-1:0] out_uop;
  logic [REG_LEN-1:0]   out_rd;
  logic [REG_NUM-1:0]   busy;

  always #5 clock = ~clock;

  ysyx_isu #(.REG_NUM(REG_NUM), .REG_LEN(REG_LEN), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_uop(in_uop),
    .in_rd(in_rd), .in_rd_en(in_rd_en), .in_rs1(in_rs1), .in_rs1_en(in_rs1_en),
    .in_rs2(in_rs2), .in_rs2_en(in_rs2_en), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_uop(out_uop),
    .out_rd(out_rd), .out_rd_en(out_rd_en), .busy(busy), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: which registers have a producer in flight, plus the slot.
  bit                   m_busy [REG_NUM];
  bit                   m_valid;
  logic [31:0]          m_pc;
  logic [PAYLOAD_W-1:0] m_uop;
  logic [REG_LEN-1:0]   m_rd;
  bit                   m_rd_en;
  logic [31:0]          m_stall;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [REG_NUM-1:0] model_busy_vec();
    logic [REG_NUM-1:0] v;
    v = '0;
    for (int i = 1; i < REG_NUM; i++) if (m_busy[i]) v[i] = 1'b1;
    return v;
  endfunction

  // A register is still outstanding unless it is x0 or being written back now.
  function automatic bit blocked(input logic [REG_LEN-1:0] r, input logic en);
    return en && (r != 0) && m_busy[r] && !(wb_valid && (wb_rd == r));
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_uop = '0;
    in_rd = '0; in_rd_en = 1'b0; in_rs1 = '0; in_rs1_en = 1'b0;
    in_rs2 = '0; in_rs2_en = 1'b0; wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [REG_LEN-1:0] rd, input logic rd_en,
                        input logic [REG_LEN-1:0] rs1, input logic rs1_en,
                        input logic [REG_LEN-1:0] rs2, input logic rs2_en);
    in_valid = 1'b1; in_pc = pc; in_uop = {pc, ~pc, pc ^ 32'h5a5a_5a5a, 32'hc0de_0000 | pc};
    in_rd = rd; in_rd_en = rd_en; in_rs1 = rs1; in_rs1_en = rs1_en;
    in_rs2 = rs2; in_rs2_en = rs2_en;
  endtask

  task automatic expect_ready(input string name, input logic exp);
    #1;
    check(name, {127'd0, in_ready}, {127'd0, exp});
  endtask

  // One clock: check in_ready, advance the model at the edge, compare outputs.
  task automatic cycle();
    bit haz, sfree, rdy, acc;
    #1;
    haz   = blocked(in_rs1, in_rs1_en) || blocked(in_rs2, in_rs2_en) || blocked(in_rd, in_rd_en);
    sfree = !m_valid || out_ready;
    rdy   = sfree && !haz && !flush;
    acc   = in_valid && rdy;
    if (!reset) check("in_ready", {127'd0, in_ready}, {127'd0, rdy});
    @(posedge clock);
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_valid = 1'b0; m_pc = '0; m_uop = '0; m_rd = '0; m_rd_en = 1'b0; m_stall = '0;
    end else begin
      if (in_valid && haz && sfree && !flush && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (wb_valid && (wb_rd != 0)) m_busy[wb_rd] = 1'b0;
        if (acc) begin
          if (in_rd_en && (in_rd != 0)) m_busy[in_rd] = 1'b1;
          m_valid = 1'b1; m_pc = in_pc; m_uop = in_uop; m_rd = in_rd; m_rd_en = in_rd_en;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
    check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
    check("busy", {112'd0, busy}, {112'd0, model_busy_vec()});
    check("stall_cnt", {96'd0, stall_cnt}, {96'd0, m_stall});
    if (m_valid) begin
      check("out_pc", {96'd0, out_pc}, {96'd0, m_pc});
      check("out_uop", out_uop, m_uop);
      check("out_rd", {124'd0, out_rd}, {124'd0, m_rd});
      check("out_rd_en", {127'd0, out_rd_en}, {127'd0, m_rd_en});
    end
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset then idle.
    expect_ready("reset_in_ready", 1'b1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_busy", {112'd0, busy}, 128'd0);
    check("reset_stall", {96'd0, stall_cnt}, 128'd0);
    cycle();

    // Accept and issue: rd=5.
    set_op(32'h1000, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle();
    check("issue_valid", {127'd0, out_valid}, 128'd1);
    check("issue_pc", {96'd0, out_pc}, 128'h1000);
    check("issue_busy", {112'd0, busy}, 128'h0020);

    // RAW stall on x5, then released by a same-cycle writeback.
    set_op(32'h1004, 4'd6, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      expect_ready("raw_in_ready", 1'b0);
      cycle();
      check("raw_stall_cnt", {96'd0, stall_cnt}, 128'(i));
    end
    wb_valid = 1'b1; wb_rd = 4'd5;
    expect_ready("raw_bypass_ready", 1'b1);
    cycle();
    wb_valid = 1'b0;
    check("raw_issue_pc", {96'd0, out_pc}, 128'h1004);
    check("raw_busy", {112'd0, busy}, 128'h0040);
    check("raw_stall_hold", {96'd0, stall_cnt}, 128'd3);

    // Backpressure: slot holds 0x1004 for three cycles.
    set_op(32'h1008, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_ready("bp_in_ready", 1'b0);
      cycle();
      check("bp_pc_hold", {96'd0, out_pc}, 128'h1004);
      check("bp_stall_cnt", {96'd0, stall_cnt}, 128'd3);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_next_valid", {127'd0, out_valid}, 128'd1);
    check("bp_next_pc", {96'd0, out_pc}, 128'h1008);
    check("bp_busy", {112'd0, busy}, 128'h00C0);

    // Same-cycle set and clear on x3.
    set_op(32'h100C, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle();
    check("sc_busy_pre", {112'd0, busy}, 128'h00C8);
    set_op(32'h1010, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    wb_valid = 1'b1; wb_rd = 4'd3;
    expect_ready("sc_in_ready", 1'b1);
    cycle();
    wb_valid = 1'b0;
    check("sc_busy_post", {112'd0, busy}, 128'h00C8);
    check("sc_pc", {96'd0, out_pc}, 128'h1010);

    // x0 never sets busy and never stalls.
    set_op(32'h1014, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1);
    expect_ready("x0_in_ready", 1'b1);
    cycle();
    check("x0_busy", {112'd0, busy}, 128'h00C8);
    check("x0_pc", {96'd0, out_pc}, 128'h1014);

    // Build busy=0x00F0 with a full slot, then flush.
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd3;
    cycle();
    wb_valid = 1'b0;
    set_op(32'h1018, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle();
    set_op(32'h101C, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    cycle();
    check("fl_busy_pre", {112'd0, busy}, 128'h00F0);
    check("fl_valid_pre", {127'd0, out_valid}, 128'd1);
    set_op(32'h2000, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 4'd6;
    expect_ready("fl_in_ready", 1'b0);
    cycle();
    check("fl_valid", {127'd0, out_valid}, 128'd0);
    check("fl_busy", {112'd0, busy}, 128'd0);
    idle_inputs();
    cycle();
    check("fl_not_accepted", {127'd0, out_valid}, 128'd0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(199) == 0);
      flush     = ($urandom_range(49) == 0);
      in_valid  = ($urandom_range(99) < 75);
      in_pc     = $urandom;
      in_uop    = {$urandom, $urandom, $urandom, $urandom};
      in_rd     = REG_LEN'($urandom_range(REG_NUM - 1));
      in_rs1    = REG_LEN'($urandom_range(REG_NUM - 1));
      in_rs2    = REG_LEN'($urandom_range(REG_NUM - 1));
      in_rd_en  = ($urandom_range(99) < 70);
      in_rs1_en = ($urandom_range(99) < 60);
      in_rs2_en = ($urandom_range(99) < 40);
      wb_valid  = ($urandom_range(99) < 40);
      wb_rd     = REG_LEN'($urandom_range(REG_NUM - 1));
      out_ready = ($urandom_range(99) < 70);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
